// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one memory request/response port between two masters:
//   m0 = instruction fetch, m1 = execute-stage memory unit.
//   Requests are arbitrated round-robin; a request held by a stalled memory
//   keeps its grant until accepted. An in-order owner FIFO remembers who
//   issued each request so every memory response goes back to its issuer.
//   An orphan response (nothing outstanding) is refused and flagged sticky.

module mem_port_arbiter #(
    parameter int REQ_W  = 64,
    parameter int RESP_W = 32,
    parameter int DEPTH  = 2
) (
    input  logic                       clk,
    input  logic                       rst,

    // fetch request channel
    input  logic                       m0_req_valid,
    output logic                       m0_req_ready,
    input  logic [REQ_W-1:0]           m0_req_data,

    // execute request channel
    input  logic                       m1_req_valid,
    output logic                       m1_req_ready,
    input  logic [REQ_W-1:0]           m1_req_data,

    // fetch response channel
    output logic                       m0_resp_valid,
    input  logic                       m0_resp_ready,
    output logic [RESP_W-1:0]          m0_resp_data,

    // execute response channel
    output logic                       m1_resp_valid,
    input  logic                       m1_resp_ready,
    output logic [RESP_W-1:0]          m1_resp_data,

    // memory side
    output logic                       mem_req_valid,
    input  logic                       mem_req_ready,
    output logic [REQ_W-1:0]           mem_req_data,
    input  logic                       mem_resp_valid,
    output logic                       mem_resp_ready,
    input  logic [RESP_W-1:0]          mem_resp_data,

    // status
    output logic [$clog2(DEPTH+1)-1:0] outstanding,
    output logic                       err_orphan
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);

    // Master identifiers as stored in the owner FIFO and grant signals.
    localparam logic ID_M0 = 1'b0;
    localparam logic ID_M1 = 1'b1;

    // OPEN: free to arbitrate. LOCKED: a request is waiting on the memory and
    // its master must keep the grant so the payload stays stable.
    typedef enum logic {
        ARB_OPEN   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_t;

    arb_state_t       state_q, state_d;
    logic             lock_id_q, lock_id_d;
    logic             last_grant_q;

    logic [CNT_W-1:0] count_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic             owner_mem [DEPTH];

    logic             grant;
    logic             sel_req_valid;
    logic             can_issue;
    logic             req_fire;
    logic             head_id;
    logic             has_outstanding;
    logic             sel_resp_ready;
    logic             resp_fire;

    // ------------------------------------------------------------------
    // Request side
    // ------------------------------------------------------------------

    // Issue only when a slot is free in the registered count; a response
    // popped in the same cycle frees its slot for the next cycle only.
    assign can_issue = (count_q < CNT_W'(DEPTH));

    // Select the master: locked owner first, then a lone requester, then
    // whichever master did not win the last handshake.
    always_comb begin
        // NOTE: every signal written in an always_comb gets a default first so
        // no path leaves it unassigned and no latch is inferred.
        grant = ~last_grant_q;
        if (state_q == ARB_LOCKED) begin
            grant = lock_id_q;
        end else if (m0_req_valid && !m1_req_valid) begin
            grant = ID_M0;
        end else if (m1_req_valid && !m0_req_valid) begin
            grant = ID_M1;
        end
    end

    assign sel_req_valid = (grant == ID_M1) ? m1_req_valid : m0_req_valid;
    assign mem_req_data  = (grant == ID_M1) ? m1_req_data  : m0_req_data;

    // Valid/ready outputs are forced low while reset is held.
    assign mem_req_valid = !rst && can_issue && sel_req_valid;
    assign m0_req_ready  = !rst && (grant == ID_M0) && can_issue && mem_req_ready;
    assign m1_req_ready  = !rst && (grant == ID_M1) && can_issue && mem_req_ready;

    assign req_fire = mem_req_valid && mem_req_ready;

    // Lock next-state: a refused request pins the grant, the handshake frees it.
    always_comb begin
        state_d   = state_q;
        lock_id_d = lock_id_q;
        if (req_fire) begin
            state_d = ARB_OPEN;
        end else if (mem_req_valid) begin
            state_d   = ARB_LOCKED;
            lock_id_d = grant;
        end
    end

    // Lock state, lock owner and round-robin history registers.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            state_q      <= ARB_OPEN;
            lock_id_q    <= ID_M0;
            last_grant_q <= ID_M1;
        end else begin
            state_q   <= state_d;
            lock_id_q <= lock_id_d;
            if (req_fire) begin
                last_grant_q <= grant;
            end
        end
    end

    // ------------------------------------------------------------------
    // Response side
    // ------------------------------------------------------------------

    assign has_outstanding = (count_q != '0);
    assign head_id         = owner_mem[rd_ptr_q];
    assign sel_resp_ready  = (head_id == ID_M1) ? m1_resp_ready : m0_resp_ready;

    // Only the FIFO head may see the response; a stalled head blocks the rest.
    assign mem_resp_ready = !rst && has_outstanding && sel_resp_ready;
    assign m0_resp_valid  = !rst && mem_resp_valid && has_outstanding && (head_id == ID_M0);
    assign m1_resp_valid  = !rst && mem_resp_valid && has_outstanding && (head_id == ID_M1);
    assign m0_resp_data   = mem_resp_data;
    assign m1_resp_data   = mem_resp_data;

    assign resp_fire = mem_resp_valid && mem_resp_ready;

    // Owner FIFO storage: record the issuing master on each accepted request.
    always_ff @(posedge clk) begin
        // NOTE: the storage array has no reset; an entry is only read while
        // count_q says it holds a live owner, so its power-up value is unused.
        if (req_fire) begin
            owner_mem[wr_ptr_q] <= grant;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally as DEPTH is a power of 2.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (req_fire) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (resp_fire) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({req_fire, resp_fire})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Sticky error for a response that arrives with nothing outstanding.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_orphan <= 1'b0;
        end else if (mem_resp_valid && !has_outstanding) begin
            err_orphan <= 1'b1;
        end
    end

    assign outstanding = count_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Directed scenarios plus a randomized run against a transaction-level
//   reference model: a queue of owners, the last winner, a pending-lock flag,
//   and per-master queues of expected response data from a simple memory.

module tb_mem_port_arbiter;

    localparam int REQ_W  = 64;
    localparam int RESP_W = 32;
    localparam int DEPTH  = 2;
    localparam int CNT_W  = $clog2(DEPTH + 1);

    logic                clk;
    logic                rst;
    logic                m0_req_valid, m0_req_ready;
    logic [REQ_W-1:0]    m0_req_data;
    logic                m1_req_valid, m1_req_ready;
    logic [REQ_W-1:0]    m1_req_data;
    logic                m0_resp_valid, m0_resp_ready;
    logic [RESP_W-1:0]   m0_resp_data;
    logic                m1_resp_valid, m1_resp_ready;
    logic [RESP_W-1:0]   m1_resp_data;
    logic                mem_req_valid, mem_req_ready;
    logic [REQ_W-1:0]    mem_req_data;
    logic                mem_resp_valid, mem_resp_ready;
    logic [RESP_W-1:0]   mem_resp_data;
    logic [CNT_W-1:0]    outstanding;
    logic                err_orphan;

    mem_port_arbiter #(.REQ_W(REQ_W), .RESP_W(RESP_W), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .m0_req_valid   (m0_req_valid),
        .m0_req_ready   (m0_req_ready),
        .m0_req_data    (m0_req_data),
        .m1_req_valid   (m1_req_valid),
        .m1_req_ready   (m1_req_ready),
        .m1_req_data    (m1_req_data),
        .m0_resp_valid  (m0_resp_valid),
        .m0_resp_ready  (m0_resp_ready),
        .m0_resp_data   (m0_resp_data),
        .m1_resp_valid  (m1_resp_valid),
        .m1_resp_ready  (m1_resp_ready),
        .m1_resp_data   (m1_resp_data),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_data   (mem_req_data),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_ready (mem_resp_ready),
        .mem_resp_data  (mem_resp_data),
        .outstanding    (outstanding),
        .err_orphan     (err_orphan)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    // ---------------- stimulus state ----------------
    bit   [1:0]        m_valid;
    logic [REQ_W-1:0]  m_data [2];
    bit   [1:0]        r_ready;
    bit                mr_ready;
    bit                mresp_valid;
    logic [RESP_W-1:0] mresp_data;
    int                p_req, p_rready, p_mready, p_mresp;
    bit                e2e;

    // ---------------- reference model ----------------
    bit                q[$];          // owners of outstanding requests, oldest first
    bit                last_grant;
    bit                locked;
    bit                lock_id;
    bit                err;
    logic [REQ_W-1:0]  mem_pend[$];   // requests the memory owes a response for
    logic [RESP_W-1:0] exp_resp0[$];
    logic [RESP_W-1:0] exp_resp1[$];
    bit                acc_log[$];    // sequence of accepted masters
    bit   [1:0]        accepted;
    bit                resp_fired;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [RESP_W-1:0] resp_of(input logic [REQ_W-1:0] d);
        return d[31:0] ^ d[63:32] ^ 32'h5A5A_0F0F;
    endfunction

    task automatic apply();
        m0_req_valid   = m_valid[0];
        m0_req_data    = m_data[0];
        m1_req_valid   = m_valid[1];
        m1_req_data    = m_data[1];
        m0_resp_ready  = r_ready[0];
        m1_resp_ready  = r_ready[1];
        mem_req_ready  = mr_ready;
        mem_resp_valid = mresp_valid;
        mem_resp_data  = mresp_data;
    endtask

    task automatic clear_stim();
        m_valid     = 2'b00;
        m_data[0]   = '0;
        m_data[1]   = '0;
        r_ready     = 2'b00;
        mr_ready    = 1'b0;
        mresp_valid = 1'b0;
        mresp_data  = '0;
    endtask

    // Assert reset away from a clock edge with hostile inputs, check all
    // handshake outputs and status are cleared at once, then clear the model.
    task automatic do_reset();
        @(negedge clk);
        #2;
        rst = 1'b1;
        m_valid = 2'b11; r_ready = 2'b11; mr_ready = 1'b1; mresp_valid = 1'b1;
        apply();
        #1;
        check("rst_outstanding",    64'(outstanding),    64'd0);
        check("rst_err_orphan",     64'(err_orphan),     64'd0);
        check("rst_mem_req_valid",  64'(mem_req_valid),  64'd0);
        check("rst_m0_req_ready",   64'(m0_req_ready),   64'd0);
        check("rst_m1_req_ready",   64'(m1_req_ready),   64'd0);
        check("rst_mem_resp_ready", 64'(mem_resp_ready), 64'd0);
        check("rst_m0_resp_valid",  64'(m0_resp_valid),  64'd0);
        check("rst_m1_resp_valid",  64'(m1_resp_valid),  64'd0);
        q.delete(); mem_pend.delete(); exp_resp0.delete(); exp_resp1.delete(); acc_log.delete();
        last_grant = 1'b1; locked = 1'b0; lock_id = 1'b0; err = 1'b0;
        accepted = 2'b00; resp_fired = 1'b0;
        clear_stim();
        apply();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // One clock cycle: drive at the falling edge, check settled outputs
    // against the model, then advance the model to what the next rising
    // edge must produce.
    task automatic step();
        bit g, can, emv, fire, rfire, head, anyv;
        logic [RESP_W-1:0] ed;
        @(negedge clk);
        apply();
        #1;
        can  = (q.size() < DEPTH);
        anyv = m_valid[0] | m_valid[1];
        head = (q.size() > 0) ? q[0] : 1'b0;
        if (locked)                        g = lock_id;
        else if (m_valid[0] && !m_valid[1]) g = 1'b0;
        else if (m_valid[1] && !m_valid[0]) g = 1'b1;
        else                                g = !last_grant;
        emv = can && m_valid[g];

        check("mem_req_valid", 64'(mem_req_valid), 64'(emv));
        if (emv) check("mem_req_data", mem_req_data, m_data[g]);
        if (anyv || locked) begin
            check("m0_req_ready", 64'(m0_req_ready), 64'((g == 1'b0) && can && mr_ready));
            check("m1_req_ready", 64'(m1_req_ready), 64'((g == 1'b1) && can && mr_ready));
        end
        check("m0_resp_valid", 64'(m0_resp_valid), 64'(mresp_valid && q.size() > 0 && head == 1'b0));
        check("m1_resp_valid", 64'(m1_resp_valid), 64'(mresp_valid && q.size() > 0 && head == 1'b1));
        check("mem_resp_ready", 64'(mem_resp_ready), 64'(q.size() > 0 && r_ready[head]));
        if (mresp_valid && q.size() > 0) begin
            if (head) check("m1_resp_data", 64'(m1_resp_data), 64'(mresp_data));
            else      check("m0_resp_data", 64'(m0_resp_data), 64'(mresp_data));
        end
        check("outstanding", 64'(outstanding), 64'(q.size()));
        check("err_orphan",  64'(err_orphan),  64'(err));

        fire  = emv && mr_ready;
        rfire = mresp_valid && (q.size() > 0) && r_ready[head];
        accepted = 2'b00;
        if (mresp_valid && q.size() == 0) err = 1'b1;
        if (rfire) begin
            void'(q.pop_front());
            if (mem_pend.size() > 0) void'(mem_pend.pop_front());
            if (head && exp_resp1.size() > 0) begin
                ed = exp_resp1.pop_front();
                if (e2e) check("m1_resp_e2e", 64'(m1_resp_data), 64'(ed));
            end else if (!head && exp_resp0.size() > 0) begin
                ed = exp_resp0.pop_front();
                if (e2e) check("m0_resp_e2e", 64'(m0_resp_data), 64'(ed));
            end
        end
        resp_fired = rfire;
        if (fire) begin
            q.push_back(g);
            mem_pend.push_back(m_data[g]);
            if (g) exp_resp1.push_back(resp_of(m_data[g]));
            else   exp_resp0.push_back(resp_of(m_data[g]));
            acc_log.push_back(g);
            last_grant  = g;
            locked      = 1'b0;
            accepted[g] = 1'b1;
        end else if (emv) begin
            locked  = 1'b1;
            lock_id = g;
        end
    endtask

    // Random masters hold a request until accepted; the memory model answers
    // its oldest pending request and holds the response until taken.
    task automatic gen_random();
        for (int x = 0; x < 2; x++) begin
            if (accepted[x] || !m_valid[x]) begin
                if ($urandom_range(99) < p_req) begin
                    m_valid[x] = 1'b1;
                    m_data[x]  = {$urandom, $urandom};
                end else begin
                    m_valid[x] = 1'b0;
                end
            end
            r_ready[x] = ($urandom_range(99) < p_rready);
        end
        mr_ready = ($urandom_range(99) < p_mready);
        if (mresp_valid && !resp_fired) begin
            // hold the current response
        end else if (mem_pend.size() > 0 && $urandom_range(99) < p_mresp) begin
            mresp_valid = 1'b1;
            mresp_data  = resp_of(mem_pend[0]);
        end else begin
            mresp_valid = 1'b0;
            mresp_data  = $urandom;
        end
    endtask

    initial begin
        rst = 1'b1;
        e2e = 1'b0;
        clear_stim();
        apply();

        // ---- 1: single fetch request, response two cycles later ----
        do_reset();
        m_valid = 2'b01; m_data[0] = 64'h1000; mr_ready = 1'b1; r_ready = 2'b11;
        step();
        check("t1_req_data", mem_req_data, 64'h1000);
        m_valid = 2'b00;
        step();
        check("t1_out_1", 64'(outstanding), 64'd1);
        step();
        mresp_valid = 1'b1; mresp_data = 32'hDEAD_BEEF;
        step();
        check("t1_m0_resp_valid", 64'(m0_resp_valid), 64'd1);
        check("t1_m0_resp_data",  64'(m0_resp_data),  64'hDEAD_BEEF);
        check("t1_m1_resp_valid", 64'(m1_resp_valid), 64'd0);
        mresp_valid = 1'b0;
        step();
        check("t1_out_0", 64'(outstanding), 64'd0);

        // ---- 2: both always valid, immediate memory -> alternating grants ----
        do_reset();
        e2e = 1'b1;
        p_req = 100; p_rready = 100; p_mready = 100; p_mresp = 100;
        for (int i = 0; i < 8; i++) begin
            gen_random();
            step();
        end
        check("t2_accepted_count_ge4", 64'(acc_log.size() >= 4), 64'd1);
        if (acc_log.size() >= 4) begin
            for (int i = 0; i < 4; i++) check($sformatf("t2_grant_%0d", i), 64'(acc_log[i]), 64'(i % 2));
        end

        // ---- 3: stalled memory keeps m0 locked, then m1 wins ----
        do_reset();
        e2e = 1'b0;
        m_valid = 2'b11; m_data[0] = 64'hA0A0_0000_0000_00A0; m_data[1] = 64'hB1B1_0000_0000_00B1;
        r_ready = 2'b11; mr_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("t3_hold_data", mem_req_data, 64'hA0A0_0000_0000_00A0);
            check("t3_m1_ready",  64'(m1_req_ready), 64'd0);
        end
        mr_ready = 1'b1;
        step();
        check("t3_m0_accept", 64'(m0_req_ready), 64'd1);
        m_data[0] = 64'hA2;
        step();
        check("t3_m1_next",      64'(m1_req_ready), 64'd1);
        check("t3_m1_next_data", mem_req_data, 64'hB1B1_0000_0000_00B1);

        // ---- 4: DEPTH full blocks issue until one response retires ----
        do_reset();
        m_valid = 2'b01; mr_ready = 1'b1; r_ready = 2'b11;
        m_data[0] = 64'h11; step();
        m_data[0] = 64'h22; step();
        m_data[0] = 64'h33; step();
        check("t4_full_ready", 64'(m0_req_ready), 64'd0);
        check("t4_full_count", 64'(outstanding),  64'd2);
        mresp_valid = 1'b1; mresp_data = 32'h1;
        step();
        check("t4_pop_no_issue",  64'(mem_req_valid),  64'd0);
        check("t4_pop_resp_rdy",  64'(mem_resp_ready), 64'd1);
        mresp_valid = 1'b0;
        step();
        check("t4_issue_after", 64'(m0_req_ready), 64'd1);
        check("t4_count_after", 64'(outstanding),  64'd1);

        // ---- 5: in-order routing with a stalled head ----
        do_reset();
        mr_ready = 1'b1; r_ready = 2'b11;
        m_valid = 2'b10; m_data[1] = 64'h5151; step();
        m_valid = 2'b01; m_data[0] = 64'h5050; step();
        m_valid = 2'b00;
        mresp_valid = 1'b1; mresp_data = 32'hA; r_ready = 2'b01;
        for (int i = 0; i < 2; i++) begin
            step();
            check("t5_stall_ready", 64'(mem_resp_ready), 64'd0);
            check("t5_stall_m0v",   64'(m0_resp_valid),  64'd0);
        end
        r_ready = 2'b11;
        step();
        check("t5_m1_valid", 64'(m1_resp_valid), 64'd1);
        check("t5_m1_data",  64'(m1_resp_data),  64'hA);
        mresp_data = 32'hB;
        step();
        check("t5_m0_valid", 64'(m0_resp_valid), 64'd1);
        check("t5_m0_data",  64'(m0_resp_data),  64'hB);
        check("t5_m1_idle",  64'(m1_resp_valid), 64'd0);
        mresp_valid = 1'b0;
        step();
        check("t5_drained", 64'(outstanding), 64'd0);

        // ---- 6: orphan response is sticky; reset clears it and ownership ----
        do_reset();
        mresp_valid = 1'b1; mresp_data = 32'h0BAD; r_ready = 2'b11;
        step();
        check("t6_orphan_ready", 64'(mem_resp_ready), 64'd0);
        mresp_valid = 1'b0;
        step();
        check("t6_err_set", 64'(err_orphan), 64'd1);
        m_valid = 2'b10; m_data[1] = 64'h66; mr_ready = 1'b1;
        step();
        m_valid = 2'b00;
        step();
        check("t6_err_sticky", 64'(err_orphan),  64'd1);
        check("t6_out_before", 64'(outstanding), 64'd1);
        do_reset();
        mresp_valid = 1'b1;
        step();
        mresp_valid = 1'b0;
        step();
        check("t6_orphan_after_rst", 64'(err_orphan), 64'd1);

        // ---- randomized traffic ----
        do_reset();
        e2e = 1'b1;
        p_req = 70; p_rready = 70; p_mready = 60; p_mresp = 50;
        for (int i = 0; i < 3000; i++) begin
            gen_random();
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
